// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Frame sequencer behind the 16-bit UART receiver. It hunts for a sync
//   word, then reads a length word, N payload words and a checksum word.
//   Payload words are streamed out as they arrive. The block then reports
//   either frame completion or the class of error that ended the frame.
//
// Ports
//   clock          system clock, all logic on posedge
//   reset          asynchronous active-low reset
//   rx_data        received word, sampled only when rx_valid=1
//   rx_valid       1-cycle strobe qualifying rx_data
//   payload_data   last streamed payload word (held between pulses)
//   payload_valid  1-cycle pulse per payload word
//   payload_idx    0-based index of payload_data within its frame
//   frame_done     1-cycle pulse: checksum matched
//   frame_len      length of the last accepted frame (held)
//   csum_err       1-cycle pulse: checksum mismatch
//   len_err        1-cycle pulse: length word 0 or above MAX_LEN
//   timeout_err    1-cycle pulse: inter-word gap inside a frame too long
//   busy           high while a frame is in progress
module uart_rx_frame_ctrl #(
    parameter logic [15:0] SYNC_WORD   = 16'hA55A,
    parameter int          MAX_LEN     = 16,
    parameter int          TIMEOUT_CYC = 60000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic [15:0] payload_data,
    output logic        payload_valid,
    output logic [7:0]  payload_idx,
    output logic        frame_done,
    output logic [7:0]  frame_len,
    output logic        csum_err,
    output logic        len_err,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic [1:0] {S_HUNT, S_LEN, S_DATA, S_CSUM} state_t;

    localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [15:0]   sum_q, sum_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   payload_data_q, payload_data_d;
    logic [7:0]    payload_idx_q, payload_idx_d;
    logic [7:0]    frame_len_q, frame_len_d;
    logic          payload_valid_q, payload_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          csum_err_q, csum_err_d;
    logic          len_err_q, len_err_d;
    logic          timeout_err_q, timeout_err_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        sum_d           = sum_q;
        cnt_d           = cnt_q;
        timer_d         = timer_q;
        payload_data_d  = payload_data_q;
        payload_idx_d   = payload_idx_q;
        frame_len_d     = frame_len_q;
        payload_valid_d = 1'b0;
        frame_done_d    = 1'b0;
        csum_err_d      = 1'b0;
        len_err_d       = 1'b0;
        timeout_err_d   = 1'b0;

        // A word arriving on the expiry cycle beats the timeout because
        // the timer branch is only taken when rx_valid is low.
        if (rx_valid || state_q == S_HUNT) begin
            timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = S_HUNT;
            timer_d       = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        if (rx_valid) begin
            case (state_q)
                S_HUNT: begin
                    if (rx_data == SYNC_WORD) state_d = S_LEN;
                end
                S_LEN: begin
                    // Full 16-bit range check; a sync word here is just a bad length.
                    if (rx_data != 16'd0 && rx_data <= MAX_LEN_W) begin
                        len_d   = rx_data[7:0];
                        sum_d   = rx_data;
                        cnt_d   = 8'd0;
                        state_d = S_DATA;
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
                S_DATA: begin
                    payload_data_d  = rx_data;
                    payload_idx_d   = cnt_q;
                    payload_valid_d = 1'b1;
                    sum_d           = sum_q + rx_data;
                    cnt_d           = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) state_d = S_CSUM;
                end
                S_CSUM: begin
                    if (rx_data == sum_q) begin
                        frame_done_d = 1'b1;
                        frame_len_d  = len_q;
                    end else begin
                        csum_err_d = 1'b1;
                    end
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end

        busy_d = (state_d != S_HUNT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_HUNT;
            len_q           <= '0;
            sum_q           <= '0;
            cnt_q           <= '0;
            timer_q         <= '0;
            payload_data_q  <= '0;
            payload_idx_q   <= '0;
            frame_len_q     <= '0;
            payload_valid_q <= 1'b0;
            frame_done_q    <= 1'b0;
            csum_err_q      <= 1'b0;
            len_err_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            sum_q           <= sum_d;
            cnt_q           <= cnt_d;
            timer_q         <= timer_d;
            payload_data_q  <= payload_data_d;
            payload_idx_q   <= payload_idx_d;
            frame_len_q     <= frame_len_d;
            payload_valid_q <= payload_valid_d;
            frame_done_q    <= frame_done_d;
            csum_err_q      <= csum_err_d;
            len_err_q       <= len_err_d;
            timeout_err_q   <= timeout_err_d;
            busy_q          <= busy_d;
        end
    end

    assign payload_data  = payload_data_q;
    assign payload_valid = payload_valid_q;
    assign payload_idx   = payload_idx_q;
    assign frame_done    = frame_done_q;
    assign frame_len     = frame_len_q;
    assign csum_err      = csum_err_q;
    assign len_err       = len_err_q;
    assign timeout_err   = timeout_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

    localparam logic [15:0] SYNC = 16'hA55A;
    localparam int          MAXL = 16;
    localparam int          T    = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [15:0] payload_data;
    logic        payload_valid;
    logic [7:0]  payload_idx;
    logic        frame_done;
    logic [7:0]  frame_len;
    logic        csum_err;
    logic        len_err;
    logic        timeout_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Expected observation after one clock; field order matches 'got' below.
    typedef struct packed {
        logic        pv;
        logic        done;
        logic        cerr;
        logic        lerr;
        logic        tmo;
        logic        busy;
        logic [7:0]  idx;
        logic [15:0] data;
        logic [7:0]  flen;
    } exp_t;

    logic [15:0] stim[$];
    logic [7:0]  m_flen  = 8'd0;
    logic [7:0]  m_pidx  = 8'd0;
    logic [15:0] m_pdata = 16'd0;

    uart_rx_frame_ctrl #(
        .SYNC_WORD  (SYNC),
        .MAX_LEN    (MAXL),
        .TIMEOUT_CYC(T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .payload_data (payload_data),
        .payload_valid(payload_valid),
        .payload_idx  (payload_idx),
        .frame_done   (frame_done),
        .frame_len    (frame_len),
        .csum_err     (csum_err),
        .len_err      (len_err),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

    // Append one frame: sync, length, L random words, checksum (optionally corrupted).
    task automatic push_frame(input int L, input bit bad);
        logic [15:0] s, v;
        stim.push_back(SYNC);
        stim.push_back(16'(L));
        s = 16'(L);
        for (int k = 0; k < L; k++) begin
            v = 16'($urandom);
            stim.push_back(v);
            s = s + v;
        end
        stim.push_back(bad ? s + 16'(1 + $urandom_range(0, 999)) : s);
    endtask

    // Predict per-word responses for 'stim' by parsing it as frames, then
    // drive it with gmin..gmax idle clocks after each word and compare.
    task automatic run_stream(input int gmin, input int gmax, input string tag);
        exp_t e[256];
        exp_t ex, got;
        int n, i, L, g;
        logic [15:0] s;
        n = stim.size();
        for (int k = 0; k < n; k++) e[k] = '0;
        i = 0;
        while (i < n) begin
            if (stim[i] != SYNC) begin i++; continue; end
            e[i].busy = 1'b1; i++;
            if (i >= n) break;
            L = int'(stim[i]);
            if (L < 1 || L > MAXL) begin e[i].lerr = 1'b1; i++; continue; end
            e[i].busy = 1'b1; s = stim[i]; i++;
            for (int k = 0; k < L && i < n; k++) begin
                e[i].pv = 1'b1; e[i].idx = 8'(k); e[i].data = stim[i]; e[i].busy = 1'b1;
                s = s + stim[i]; i++;
            end
            if (i >= n) break;
            if (stim[i] == s) begin e[i].done = 1'b1; e[i].flen = 8'(L); end
            else e[i].cerr = 1'b1;
            i++;
        end
        // Held outputs carry the most recent reported values forward.
        for (int k = 0; k < n; k++) begin
            if (e[k].pv) begin m_pidx = e[k].idx; m_pdata = e[k].data; end
            if (e[k].done) m_flen = e[k].flen;
            e[k].idx = m_pidx; e[k].data = m_pdata; e[k].flen = m_flen;
        end

        for (int k = 0; k < n; k++) begin
            rx_data  = stim[k];
            rx_valid = 1'b1;
            @(negedge clock);
            rx_valid = 1'b0;
            got = {payload_valid, frame_done, csum_err, len_err, timeout_err, busy,
                   payload_idx, payload_data, frame_len};
            tests++;
            if (got !== e[k]) begin
                fails++;
                $display("FAIL %s word%0d (%h): got %h expected %h", tag, k, stim[k], got, e[k]);
            end
            ex = e[k];
            ex.pv = 1'b0; ex.done = 1'b0; ex.cerr = 1'b0; ex.lerr = 1'b0;
            g = $urandom_range(gmax, gmin);
            for (int c = 0; c < g; c++) begin
                rx_data = 16'($urandom);
                @(negedge clock);
                got = {payload_valid, frame_done, csum_err, len_err, timeout_err, busy,
                       payload_idx, payload_data, frame_len};
                tests++;
                if (got !== ex) begin
                    fails++;
                    $display("FAIL %s idle after word%0d: got %h expected %h", tag, k, got, ex);
                end
            end
        end
        stim.delete();
    endtask

    task automatic test_reset();
        logic [37:0] got;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 16'h0;
        repeat (3) @(negedge clock);
        got = {payload_valid, frame_done, csum_err, len_err, timeout_err, busy,
               payload_idx, payload_data, frame_len};
        tests++;
        if (got !== 38'd0) begin
            fails++;
            $display("FAIL reset_state: got %h expected 0", got);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        stim = {16'hA55A, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0009};
        run_stream(0, 2, "basic3");
        stim = {16'hA55A, 16'h0002, 16'hFFFF, 16'h0003, 16'h0004};
        run_stream(0, 2, "sum_wrap");
        stim = {16'hA55A, 16'h0002, 16'h0001, 16'h0002, 16'h0000};
        run_stream(0, 2, "csum_bad");
        stim = {16'hA55A, 16'h0000, 16'hA55A, 16'h0011, 16'hA55A, 16'hA55A};
        run_stream(0, 2, "len_bad");
        stim = {16'h1234, 16'hA55A, 16'h0001, 16'h0005, 16'h0006};
        run_stream(0, 2, "junk_first");
        push_frame(MAXL, 1'b0);
        stim.push_back(SYNC);
        stim.push_back(16'(MAXL + 1));
        run_stream(0, 1, "len_limit");
    endtask

    task automatic test_back_to_back();
        push_frame(1, 1'b0);
        push_frame(5, 1'b0);
        push_frame(3, 1'b1);
        push_frame(16, 1'b0);
        push_frame(2, 1'b0);
        run_stream(0, 0, "b2b");
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 12; it++) begin
            for (int f = 0; f < 8; f++) begin
                r = $urandom_range(0, 9);
                case (r)
                    5: push_frame($urandom_range(1, MAXL), 1'b1);
                    6: begin stim.push_back(SYNC); stim.push_back(16'h0000); end
                    7: begin stim.push_back(SYNC); stim.push_back(16'($urandom_range(MAXL + 1, 65535))); end
                    8: stim.push_back(16'($urandom));
                    default: push_frame($urandom_range(1, MAXL), 1'b0);
                endcase
            end
            run_stream(0, 3, "random");
        end
    endtask

    task automatic test_timeout();
        // Partial frame left idle: expiry after exactly T idle clocks.
        stim = {16'hA55A, 16'h0002, 16'h0001};
        run_stream(0, 0, "tmo_head");
        for (int c = 0; c < T - 1; c++) begin
            @(negedge clock);
            tests++;
            if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL tmo_early idle%0d: timeout_err=%b busy=%b expected 0/1", c, timeout_err, busy);
            end
        end
        @(negedge clock);
        tests++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || payload_valid !== 1'b0) begin
            fails++;
            $display("FAIL tmo_fire: timeout_err=%b busy=%b pv=%b expected 1/0/0", timeout_err, busy, payload_valid);
        end
        @(negedge clock);
        tests++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_pulse_width: timeout_err=%b busy=%b expected 0/0", timeout_err, busy);
        end
        push_frame(4, 1'b0);
        run_stream(0, 1, "after_tmo");
        // Words arriving exactly on the expiry clock keep the frame alive.
        push_frame(3, 1'b0);
        run_stream(T - 1, T - 1, "tmo_edge");
    endtask

    task automatic test_reset_mid();
        logic [37:0] got;
        stim = {16'hA55A, 16'h0003, 16'h0007, 16'h0008};
        run_stream(0, 1, "pre_reset");
        reset = 1'b0;
        #1;
        got = {payload_valid, frame_done, csum_err, len_err, timeout_err, busy,
               payload_idx, payload_data, frame_len};
        tests++;
        if (got !== 38'd0) begin
            fails++;
            $display("FAIL reset_mid_async: got %h expected 0", got);
        end
        @(negedge clock);
        reset = 1'b1;
        m_flen = 8'd0; m_pidx = 8'd0; m_pdata = 16'd0;
        rx_data = 16'h0009;
        @(negedge clock);
        got = {payload_valid, frame_done, csum_err, len_err, timeout_err, busy,
               payload_idx, payload_data, frame_len};
        tests++;
        if (got !== 38'd0) begin
            fails++;
            $display("FAIL reset_mid_after: got %h expected 0", got);
        end
        push_frame(3, 1'b0);
        run_stream(0, 2, "post_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
